// File: rtl/mvu_apb_ctrl_if.sv
// rtl/mvu_apb_ctrl_if.sv - APB bus bundle between the host and the MVU register block
// Ports (slave view):
//   paddr, psel, penable, pwrite, pwdata : requester to register block
//   pready, prdata, pslverr               : register block to requester
interface mvu_apb_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );
endinterface

// File: rtl/mvu_apb_ctrl.sv
// rtl/mvu_apb_ctrl.sv - APB control/status registers that configure, launch and track MVU jobs
// Ports:
//   clk, rst      : shared clock, synchronous active-high reset
//   bus           : APB slave (zero wait states, combinational prdata/pslverr)
//   mvu_start     : one-cycle launch pulse, the cycle after the START write commits
//   mvu_done      : one-cycle completion pulse from the MVU
//   mvu_wprec/iprec/oprec, mvu_countdown, mvu_scaler, mvu_bias,
//   mvu_quant_msb, mvu_relu_en : job configuration, straight from registers
//   irq           : registered DONE & IRQ_EN
module mvu_apb_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    mvu_apb_ctrl_if.slave      bus,
    output logic               mvu_start,
    input  logic               mvu_done,
    output logic [5:0]         mvu_wprec,
    output logic [5:0]         mvu_iprec,
    output logic [5:0]         mvu_oprec,
    output logic [31:0]        mvu_countdown,
    output logic [15:0]        mvu_scaler,
    output logic signed [31:0] mvu_bias,
    output logic [5:0]         mvu_quant_msb,
    output logic               mvu_relu_en,
    output logic               irq
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] IDX_CTRL      = IW'(0);
    localparam logic [IW-1:0] IDX_STATUS    = IW'(1);
    localparam logic [IW-1:0] IDX_PREC      = IW'(2);
    localparam logic [IW-1:0] IDX_COUNTDOWN = IW'(3);
    localparam logic [IW-1:0] IDX_SCALER    = IW'(4);
    localparam logic [IW-1:0] IDX_BIAS      = IW'(5);
    localparam logic [IW-1:0] IDX_QUANT     = IW'(6);
    localparam logic [IW-1:0] IDX_RELU      = IW'(7);
    localparam logic [IW-1:0] IDX_ID        = IW'(8);
    localparam logic [31:0]   ID_VALUE      = 32'h4D56_5501;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t state, state_nx;

    logic        irq_en;
    logic        done;
    logic [17:0] prec;
    logic [31:0] countdown;
    logic [15:0] scaler;
    logic [31:0] bias;
    logic [5:0]  quant_msb;
    logic        relu_en;
    logic        start_q;
    logic        irq_q;

    logic [IW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mapped;
    logic                  read_only;
    logic                  access;
    logic                  busy;
    logic                  start_req;
    logic                  err;
    logic                  reg_wr;
    logic                  ctrl_wr;
    logic                  launch;
    logic                  done_set;
    logic                  unused_paddr_lsbs;

    // Byte address; the two LSBs do not take part in decode.
    assign word_idx          = bus.paddr[ADDR_WIDTH-1:2];
    assign unused_paddr_lsbs = ^bus.paddr[1:0];

    assign access = bus.psel & bus.penable;
    assign busy   = (state == S_BUSY);

    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (word_idx)
            IDX_CTRL:      rdata = DATA_WIDTH'({irq_en, 1'b0});
            IDX_STATUS:    rdata = DATA_WIDTH'({done, busy});
            IDX_PREC:      rdata = DATA_WIDTH'(prec);
            IDX_COUNTDOWN: rdata = DATA_WIDTH'(countdown);
            IDX_SCALER:    rdata = DATA_WIDTH'(scaler);
            IDX_BIAS:      rdata = DATA_WIDTH'(bias);
            IDX_QUANT:     rdata = DATA_WIDTH'(quant_msb);
            IDX_RELU:      rdata = DATA_WIDTH'(relu_en);
            IDX_ID: begin
                rdata     = DATA_WIDTH'(ID_VALUE);
                read_only = 1'b1;
            end
            default:       mapped = 1'b0;
        endcase
    end

    assign start_req = access & bus.pwrite & (word_idx == IDX_CTRL) & bus.pwdata[0];

    // A rejected START still lets its IRQ_EN bit through, hence the separate ctrl_wr.
    assign err     = access & (~mapped | (bus.pwrite & read_only) | (start_req & busy));
    assign reg_wr  = access & bus.pwrite & ~err;
    assign ctrl_wr = access & bus.pwrite & (word_idx == IDX_CTRL);

    assign bus.pready  = 1'b1;
    assign bus.prdata  = access ? rdata : '0;
    assign bus.pslverr = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        done_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    launch   = 1'b1;
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mvu_done) begin
                    done_set = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en    <= 1'b0;
            done      <= 1'b0;
            prec      <= '0;
            countdown <= '0;
            scaler    <= '0;
            bias      <= '0;
            quant_msb <= '0;
            relu_en   <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (ctrl_wr)                             irq_en    <= bus.pwdata[1];
            if (reg_wr && word_idx == IDX_PREC)      prec      <= bus.pwdata[17:0];
            if (reg_wr && word_idx == IDX_COUNTDOWN) countdown <= bus.pwdata[31:0];
            if (reg_wr && word_idx == IDX_SCALER)    scaler    <= bus.pwdata[15:0];
            if (reg_wr && word_idx == IDX_BIAS)      bias      <= bus.pwdata[31:0];
            if (reg_wr && word_idx == IDX_QUANT)     quant_msb <= bus.pwdata[5:0];
            if (reg_wr && word_idx == IDX_RELU)      relu_en   <= bus.pwdata[0];

            // Completion beats a simultaneous W1C so a finished job is never lost.
            if (launch) begin
                done <= 1'b0;
            end else if (done_set) begin
                done <= 1'b1;
            end else if (reg_wr && word_idx == IDX_STATUS && bus.pwdata[1]) begin
                done <= 1'b0;
            end

            start_q <= launch;
            irq_q   <= done & irq_en;
        end
    end

    assign mvu_start     = start_q;
    assign irq           = irq_q;
    assign mvu_wprec     = prec[5:0];
    assign mvu_iprec     = prec[11:6];
    assign mvu_oprec     = prec[17:12];
    assign mvu_countdown = countdown;
    assign mvu_scaler    = scaler;
    assign mvu_bias      = bias;
    assign mvu_quant_msb = quant_msb;
    assign mvu_relu_en   = relu_en;
endmodule

// File: tb/tb_mvu_apb_ctrl.sv
// tb/tb_mvu_apb_ctrl.sv - self-checking bench for mvu_apb_ctrl
module tb_mvu_apb_ctrl;
    logic clk;
    logic rst;
    logic mvu_start;
    logic mvu_done;
    logic [5:0] mvu_wprec, mvu_iprec, mvu_oprec, mvu_quant_msb;
    logic [31:0] mvu_countdown;
    logic [15:0] mvu_scaler;
    logic signed [31:0] mvu_bias;
    logic mvu_relu_en;
    logic irq;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    logic [31:0] exp_q[$];

    mvu_apb_ctrl_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

    mvu_apb_ctrl #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .mvu_start(mvu_start),
        .mvu_done(mvu_done),
        .mvu_wprec(mvu_wprec),
        .mvu_iprec(mvu_iprec),
        .mvu_oprec(mvu_oprec),
        .mvu_countdown(mvu_countdown),
        .mvu_scaler(mvu_scaler),
        .mvu_bias(mvu_bias),
        .mvu_quant_msb(mvu_quant_msb),
        .mvu_relu_en(mvu_relu_en),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mvu_start === 1'b1) start_cnt++;
    end

    // One APB transfer; optional mvu_done pulse aligned with the access phase.
    task automatic apb_xfer(input logic [14:0] addr, input logic wr, input logic [31:0] data,
                            input logic with_done, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        bus.paddr = addr; bus.pwrite = wr; bus.pwdata = data;
        bus.psel = 1'b1; bus.penable = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        if (with_done) mvu_done = 1'b1;
        @(negedge clk);
        rd = bus.prdata; err = bus.pslverr;
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        mvu_done = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 mvu_done = 1'b1;
        @(posedge clk); #1 mvu_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, e; logic err;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (mvu_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", mvu_start); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (bus.pready !== 1'b1) begin failures++; $display("FAIL reset_pready got=%b exp=1", bus.pready); end
        checks++; if (mvu_bias !== 32'sd0) begin failures++; $display("FAIL reset_bias got=%h exp=0", mvu_bias); end
        exp_q.push_back(32'h4D56_5501);
        apb_xfer(15'h20, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL reset_id got=%h exp=%h", rd, e); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_id_err got=%b exp=0", err); end
        exp_q.push_back(32'h0);
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL reset_status got=%h exp=%h", rd, e); end
    endtask

    task automatic test_config_regs();
        logic [14:0] addrs [6] = '{15'h08, 15'h0C, 15'h10, 15'h14, 15'h18, 15'h1C};
        logic [31:0] wvals [6] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hABCD_1234,
                                   32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] evals [6] = '{32'h0003_FFFF, 32'hDEAD_BEEF, 32'h0000_1234,
                                   32'h8000_0001, 32'h0000_003F, 32'h0000_0000};
        logic [31:0] rd, e; logic err;
        for (int i = 0; i < 6; i++) begin
            apb_xfer(addrs[i], 1'b1, wvals[i], 1'b0, rd, err);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL cfg_wr_err addr=%h got=%b exp=0", addrs[i], err); end
            exp_q.push_back(evals[i]);
            apb_xfer(addrs[i], 1'b0, 32'h0, 1'b0, rd, err);
            e = exp_q.pop_front();
            checks++; if (rd !== e) begin failures++; $display("FAIL cfg_rd addr=%h got=%h exp=%h", addrs[i], rd, e); end
        end
        checks++; if (mvu_countdown !== 32'hDEAD_BEEF) begin failures++; $display("FAIL cfg_countdown got=%h exp=deadbeef", mvu_countdown); end
        checks++; if (mvu_scaler !== 16'h1234) begin failures++; $display("FAIL cfg_scaler got=%h exp=1234", mvu_scaler); end
        checks++; if (mvu_quant_msb !== 6'h3F) begin failures++; $display("FAIL cfg_quant got=%h exp=3f", mvu_quant_msb); end
        checks++; if (mvu_relu_en !== 1'b0) begin failures++; $display("FAIL cfg_relu got=%b exp=0", mvu_relu_en); end

        apb_xfer(15'h08, 1'b1, 32'h0000_2082, 1'b0, rd, err);
        apb_xfer(15'h14, 1'b1, 32'hFFFF_FFF6, 1'b0, rd, err);
        checks++; if (mvu_wprec !== 6'd2 || mvu_iprec !== 6'd2 || mvu_oprec !== 6'd2) begin
            failures++; $display("FAIL cfg_prec got=%0d/%0d/%0d exp=2/2/2", mvu_wprec, mvu_iprec, mvu_oprec); end
        checks++; if (mvu_bias !== -32'sd10) begin failures++; $display("FAIL cfg_bias got=%0d exp=-10", mvu_bias); end
        // Low address bits are ignored: 0x0B aliases PREC.
        exp_q.push_back(32'h0000_2082);
        apb_xfer(15'h0B, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL cfg_alias got=%h exp=%h", rd, e); end
    endtask

    task automatic test_launch();
        logic [31:0] rd, e; logic err; int c0;
        c0 = start_cnt;
        apb_xfer(15'h00, 1'b1, 32'h3, 1'b0, rd, err);
        checks++; if (mvu_start !== 1'b1) begin failures++; $display("FAIL launch_start_hi got=%b exp=1", mvu_start); end
        @(posedge clk); #1;
        checks++; if (mvu_start !== 1'b0) begin failures++; $display("FAIL launch_start_lo got=%b exp=0", mvu_start); end
        checks++; if (start_cnt !== c0 + 1) begin failures++; $display("FAIL launch_pulse_cnt got=%0d exp=%0d", start_cnt, c0 + 1); end
        exp_q.push_back(32'h1);
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL launch_busy got=%h exp=%h", rd, e); end
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h2);
        pulse_done();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL done_status got=%h exp=%h", rd, e); end
        apb_xfer(15'h04, 1'b1, 32'h2, 1'b0, rd, err);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
        e = exp_q.pop_front();
        e = e & ~32'h2;
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        checks++; if (rd !== e) begin failures++; $display("FAIL w1c_status got=%h exp=%h", rd, e); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] rd, e; logic err; int c0;
        apb_xfer(15'h00, 1'b1, 32'h3, 1'b0, rd, err);
        c0 = start_cnt;
        apb_xfer(15'h00, 1'b1, 32'h1, 1'b0, rd, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL busy_start_err got=%b exp=1", err); end
        repeat (2) @(posedge clk); #1;
        checks++; if (start_cnt !== c0 + 1) begin failures++; $display("FAIL busy_no_restart got=%0d exp=%0d", start_cnt, c0 + 1); end
        exp_q.push_back(32'h1);
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL busy_stays got=%h exp=%h", rd, e); end
        exp_q.push_back(32'h0);
        apb_xfer(15'h00, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL busy_irqen_commit got=%h exp=%h", rd, e); end
        pulse_done();
        repeat (2) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", irq); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, e; logic err;
        exp_q.push_back(32'h0);
        apb_xfer(15'h40, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL unmapped_rd got=%h exp=%h", rd, e); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL unmapped_err got=%b exp=1", err); end
        apb_xfer(15'h24, 1'b0, 32'h0, 1'b0, rd, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL edge_24_err got=%b exp=1", err); end
        apb_xfer(15'h20, 1'b1, 32'h1234_5678, 1'b0, rd, err);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL id_wr_err got=%b exp=1", err); end
        exp_q.push_back(32'h4D56_5501);
        apb_xfer(15'h20, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL id_unchanged got=%h exp=%h", rd, e); end
    endtask

    task automatic test_done_race();
        logic [31:0] rd, e; logic err;
        apb_xfer(15'h00, 1'b1, 32'h1, 1'b0, rd, err);
        apb_xfer(15'h04, 1'b1, 32'h2, 1'b1, rd, err);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL race_err got=%b exp=0", err); end
        exp_q.push_back(32'h2);
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL race_done_wins got=%h exp=%h", rd, e); end
    endtask

    task automatic test_reset_mid_job();
        logic [31:0] rd, e; logic err;
        apb_xfer(15'h00, 1'b1, 32'h3, 1'b0, rd, err);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (mvu_start !== 1'b0) begin failures++; $display("FAIL rst_job_start got=%b exp=0", mvu_start); end
        checks++; if (mvu_bias !== 32'sd0) begin failures++; $display("FAIL rst_job_bias got=%h exp=0", mvu_bias); end
        exp_q.push_back(32'h0);
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL rst_job_status got=%h exp=%h", rd, e); end
        pulse_done();
        exp_q.push_back(32'h0);
        apb_xfer(15'h04, 1'b0, 32'h0, 1'b0, rd, err);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin failures++; $display("FAIL rst_job_late_done got=%h exp=%h", rd, e); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_job_irq got=%b exp=0", irq); end
    endtask

    initial begin
        rst = 1'b1;
        mvu_done = 1'b0;
        bus.paddr = '0; bus.psel = 1'b0; bus.penable = 1'b0;
        bus.pwrite = 1'b0; bus.pwdata = '0;
        test_reset();
        test_config_regs();
        test_launch();
        test_start_while_busy();
        test_errors();
        test_done_race();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mvu_apb_ctrl.md
Name: mvu_apb_ctrl

Overview:
APB-slave control/status register block for the MVU. It sits between the APB bus and the MVU external control interface. The APB side carries the APB / APB_DV signals; the MVU side carries the MVU_EXT_INTERFACE control signals. It holds the job configuration, launches a job with a one-cycle start pulse, tracks busy/done, and raises an interrupt when a job completes.

Parameters:
ADDR_WIDTH, 15, APB address width (byte address).
DATA_WIDTH, 32, APB data width; must be 32.

Ports:
clk  in  1  clock; APB and MVU side share it.
rst  in  1  synchronous, active-high reset.
paddr  in  ADDR_WIDTH  APB address.
psel  in  1  APB select.
penable  in  1  APB access phase.
pwrite  in  1  1 = write.
pwdata  in  32  write data.
pready  out  1  always 1 (zero wait states).
prdata  out  32  read data.
pslverr  out  1  error response.
mvu_start  out  1  one-cycle job launch pulse.
mvu_done  in  1  one-cycle job completion pulse from the MVU.
mvu_wprec  out  6  weight precision.
mvu_iprec  out  6  input precision.
mvu_oprec  out  6  output precision.
mvu_countdown  out  32  job length in cycles.
mvu_scaler  out  16  scaler value.
mvu_bias  out  32  signed scalar bias.
mvu_quant_msb  out  6  quantiser MSB index.
mvu_relu_en  out  1  ReLU enable.
irq  out  1  level interrupt.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - all registers and outputs 0, except pready=1;
  - ID is constant.
- APB transfer:
  - a transfer completes in the access phase (psel & penable); no wait states.
  - Writes commit at the clk edge ending the access phase.
  - prdata is combinational from paddr during the access phase; 0 otherwise.
  - pslverr is combinational and valid only during the access phase; 0 otherwise.
- Register map (word aligned, paddr[1:0] ignored):
  - 0x00 CTRL: bit0 START (write-1 trigger, reads 0); bit1 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
  - 0x08 PREC: [5:0] wprec, [11:6] iprec, [17:12] oprec (RW).
  - 0x0C COUNTDOWN [31:0] (RW).
  - 0x10 SCALER [15:0] (RW).
  - 0x14 BIAS [31:0] (RW).
  - 0x18 QUANT_MSB [5:0] (RW).
  - 0x1C RELU [0] (RW).
  - 0x20 ID: RO, 0x4D56_5501.
- Unused register bits read 0 and ignore writes.
- Errors (pslverr=1, no state change):
  - any unmapped address (read 0);
  - a write to ID;
  - a write of START=1 while BUSY=1 (the IRQ_EN part of that write still commits).
- Launch: a write of START=1 with BUSY=0:
  - sets BUSY and clears DONE at the commit edge;
  - mvu_start is high for exactly the next cycle.
- Completion: mvu_done while BUSY=1 clears BUSY and sets DONE next edge.
  - mvu_done while BUSY=0 is ignored.
- Same-cycle mvu_done and a DONE W1C write: set wins, DONE=1.
- irq = DONE & IRQ_EN, registered, so one cycle after DONE/IRQ_EN change.
- Config outputs are direct register outputs. Writes to them while BUSY are allowed; the MVU samples them on mvu_start.
- Reset mid-job: BUSY, DONE and mvu_start clear immediately. A later mvu_done is ignored.

Test Plan:
- Reset, then read 0x20 -> 0x4D565501, pslverr=0; read 0x04 -> 0; irq=0, mvu_start=0.
- Write 0x08=0x0000_2082, 0x14=0xFFFF_FFF6 -> mvu_wprec=2, mvu_iprec=2, mvu_oprec=2, mvu_bias=-10; readback matches.
- Write CTRL=0x3 -> mvu_start high for exactly 1 cycle; STATUS=0x1. Pulse mvu_done -> STATUS=0x2, irq=1 one cycle later. Write STATUS=0x2 -> irq=0.
- START while BUSY -> pslverr=1, no second mvu_start, BUSY stays 1.
- Read 0x40 -> prdata=0, pslverr=1. Write 0x20 -> pslverr=1, ID unchanged.
- Same-cycle mvu_done and DONE W1C -> DONE=1. Assert rst mid-job -> BUSY=0; a later mvu_done leaves DONE=0.
